// File: rtl/ena_burst_gen_if.sv
// Handshake bundle between the burst generator and whoever programs it.
// Suffixes are from the generator's point of view: _i are driven into it,
// _o are driven by it.
interface ena_burst_gen_if #(
  parameter int CNT_W = 8
);
  logic             start_i;
  logic [CNT_W-1:0] len_init_i;
  logic [CNT_W-1:0] gap_len_i;
  logic             ena_o;
  logic             busy_o;
  logic             done_o;
  logic [CNT_W-1:0] burst_cnt_o;

  modport slave (
    input  start_i, len_init_i, gap_len_i,
    output ena_o, busy_o, done_o, burst_cnt_o
  );

  modport master (
    output start_i, len_init_i, gap_len_i,
    input  ena_o, busy_o, done_o, burst_cnt_o
  );
endinterface

// File: rtl/ena_burst_gen.sv
// Enable-burst stimulus generator: emits bursts of shrinking length on ena,
// separated by fixed idle gaps, and pulses done once the next burst would
// fall below MIN_LEN. All outputs are flops fed from the next-state decode,
// so they line up with the state register and reset asynchronously.
module ena_burst_gen #(
  parameter int CNT_W    = 8,
  parameter int LEN_STEP = 1,
  parameter int MIN_LEN  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  ena_burst_gen_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_GAP, S_DONE} state_e;

  localparam logic [CNT_W:0]   STEP    = (CNT_W+1)'(LEN_STEP);
  localparam logic [CNT_W:0]   MINL    = (CNT_W+1)'(MIN_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;     // length of the burst in progress / next
  logic [CNT_W-1:0] gap_q, gap_d;     // gap length latched at start (>= 1)
  logic [CNT_W-1:0] cnt_q, cnt_d;     // cycles remaining after the current one
  logic [CNT_W-1:0] bcnt_q, bcnt_d;   // completed bursts, saturating
  logic             ena_q, busy_q, done_q;

  // One extra bit so that len - step wrapping below zero shows up in the MSB.
  logic [CNT_W:0] next_len;
  logic           last_burst;
  logic           len_too_short;

  assign next_len      = {1'b0, len_q} - STEP;
  assign last_burst    = next_len[CNT_W] || (next_len < MINL);
  assign len_too_short = {1'b0, bus.len_init_i} < MINL;

  // Next-state and counter updates.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    gap_d   = gap_q;
    cnt_d   = cnt_q;
    bcnt_d  = bcnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          bcnt_d = '0;
          if (len_too_short) begin
            state_d = S_DONE;
          end else begin
            len_d   = bus.len_init_i;
            gap_d   = (bus.gap_len_i == '0) ? CNT_W'(1) : bus.gap_len_i;
            cnt_d   = bus.len_init_i - 1'b1;
            state_d = S_BURST;
          end
        end
      end
      S_BURST: begin
        if (cnt_q == '0) begin
          if (bcnt_q != CNT_MAX) bcnt_d = bcnt_q + 1'b1;
          if (last_burst) begin
            cnt_d   = '0;
            state_d = S_DONE;
          end else begin
            len_d   = next_len[CNT_W-1:0];
            cnt_d   = gap_q - 1'b1;
            state_d = S_GAP;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          cnt_d   = len_q - 1'b1;
          state_d = S_BURST;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and registered output decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      gap_q   <= '0;
      cnt_q   <= '0;
      bcnt_q  <= '0;
      ena_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      gap_q   <= gap_d;
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
      ena_q   <= (state_d == S_BURST);
      busy_q  <= (state_d == S_BURST) || (state_d == S_GAP);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign bus.ena_o       = ena_q;
  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;
  assign bus.burst_cnt_o = bcnt_q;

endmodule

// File: tb/tb_ena_burst_gen.sv
// Scoreboard bench for ena_burst_gen. Two instances: A with step 1 / min 1,
// B with step 2 / min 2. Each accepted start pushes the expected burst
// (start cycle, length) and done (cycle, burst count) events; a monitor per
// instance turns observed ena runs and done pulses into events and pops.
module tb_ena_burst_gen;
  localparam int CNT_W = 8;

  typedef struct {
    int id;
    int kind;   // 0 = burst (t = first ena cycle, v = length), 1 = done (v = burst_cnt)
    int t;
    int v;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  ev_t  exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ena_burst_gen_if #(.CNT_W(CNT_W)) ia ();
  ena_burst_gen_if #(.CNT_W(CNT_W)) ib ();

  ena_burst_gen #(.CNT_W(CNT_W), .LEN_STEP(1), .MIN_LEN(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia));
  ena_burst_gen #(.CNT_W(CNT_W), .LEN_STEP(2), .MIN_LEN(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib));

  logic             ena_s[2], busy_s[2], done_s[2];
  logic [CNT_W-1:0] cnt_s[2];
  assign ena_s[0]  = ia.ena_o;  assign ena_s[1]  = ib.ena_o;
  assign busy_s[0] = ia.busy_o; assign busy_s[1] = ib.busy_o;
  assign done_s[0] = ia.done_o; assign done_s[1] = ib.done_o;
  assign cnt_s[0]  = ia.burst_cnt_o; assign cnt_s[1] = ib.burst_cnt_o;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  task automatic drive(input int id, input logic s, input int len, input int gap);
    if (id == 0) begin
      ia.start_i = s; ia.len_init_i = CNT_W'(len); ia.gap_len_i = CNT_W'(gap);
    end else begin
      ib.start_i = s; ib.len_init_i = CNT_W'(len); ib.gap_len_i = CNT_W'(gap);
    end
  endtask

  // Reference: burst lengths shrink by step until below min; gaps are
  // max(gap,1); done lands right after the last burst. Returns run length.
  function automatic int push_model(input int id, input int k, input int len, input int gap);
    int  step, minl, g, l, t, n;
    ev_t e;
    step = (id == 0) ? 1 : 2;
    minl = (id == 0) ? 1 : 2;
    g = (gap == 0) ? 1 : gap;
    l = len;
    t = k;
    n = 0;
    while (l >= minl) begin
      e = '{id, 0, t, l};
      exp_q.push_back(e);
      n++;
      t += l + g;
      l -= step;
    end
    if (n > 0) t -= g;
    e = '{id, 1, t, (n > 255) ? 255 : n};
    exp_q.push_back(e);
    return t - k;
  endfunction

  task automatic pop_check(input int id, input int kind, input int t, input int v);
    int idx;
    idx = -1;
    foreach (exp_q[i]) if (idx < 0 && exp_q[i].id == id) idx = i;
    checks++;
    if (idx < 0) begin
      errors++;
      $display("FAIL unexpected_%s dut%0d: got t=%0d v=%0d, required no event",
               (kind != 0) ? "done" : "burst", id, t, v);
    end else begin
      if (exp_q[idx].kind != kind || exp_q[idx].t != t || exp_q[idx].v != v) begin
        errors++;
        $display("FAIL event dut%0d: got kind=%0d t=%0d v=%0d, required kind=%0d t=%0d v=%0d",
                 id, kind, t, v, exp_q[idx].kind, exp_q[idx].t, exp_q[idx].v);
      end
      exp_q.delete(idx);
    end
  endtask

  // Converts ena runs and done pulses into events and checks invariants.
  task automatic monitor(input int id);
    bit in_run;
    int rs;
    in_run = 1'b0;
    rs = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_run = 1'b0;
        continue;
      end
      checks++;
      if ((busy_s[id] && done_s[id]) || (ena_s[id] && !busy_s[id])) begin
        errors++;
        $display("FAIL invariant dut%0d cyc %0d: got ena=%0b busy=%0b done=%0b, required busy&done=0 and ena->busy",
                 id, cyc, ena_s[id], busy_s[id], done_s[id]);
      end
      if (ena_s[id]) begin
        if (!in_run) begin
          in_run = 1'b1;
          rs = cyc;
        end
      end else if (in_run) begin
        in_run = 1'b0;
        pop_check(id, 0, rs, cyc - rs);
      end
      if (done_s[id]) pop_check(id, 1, cyc, int'(cnt_s[id]));
    end
  endtask

  initial fork
    monitor(0);
    monitor(1);
  join_none

  // Caller positions at a negedge; start is sampled at the following edge k.
  task automatic start_run(input int id, input int len, input int gap,
                           output int k, output int r);
    drive(id, 1'b1, len, gap);
    @(posedge clk);
    #1;
    k = cyc;
    drive(id, 1'b0, $urandom_range(0, 255), $urandom_range(0, 255));
    r = push_model(id, k, len, gap);
  endtask

  // Returns at the negedge where done is seen high.
  task automatic wait_done(input int id);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done_s[id]) return;
    end
    checks++;
    errors++;
    $display("FAIL timeout dut%0d: got no done within 400 cycles, required done", id);
  endtask

  task automatic chk_idle(input int id, input string tag);
    chk({tag, "_ena"},  int'(ena_s[id]),  0);
    chk({tag, "_busy"}, int'(busy_s[id]), 0);
    chk({tag, "_done"}, int'(done_s[id]), 0);
    chk({tag, "_cnt"},  int'(cnt_s[id]),  0);
  endtask

  task automatic run_rand(input int id);
    int k, r, len, gap;
    @(negedge clk);
    len = $urandom_range(0, 14);
    gap = $urandom_range(0, 4);
    start_run(id, len, gap, k, r);
    if (r > 8 && $urandom_range(0, 1) == 1) begin
      repeat ($urandom_range(1, 5)) @(negedge clk);
      drive(id, 1'b1, $urandom_range(0, 14), $urandom_range(0, 4));
      @(posedge clk);
      #1;
      drive(id, 1'b0, 0, 0);
    end
    wait_done(id);
    @(negedge clk);
  endtask

  initial begin
    int k, r;
    drive(0, 1'b0, 0, 0);
    drive(1, 1'b0, 0, 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_idle(0, "in_reset_a");
    chk_idle(1, "in_reset_b");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk_idle(0, "idle_a");
      chk_idle(1, "idle_b");
    end

    fork
      begin
        // 8/1 run with a start during the second burst (edge k+10).
        @(negedge clk);
        start_run(0, 8, 1, k, r);
        repeat (10) @(negedge clk);
        drive(0, 1'b1, 4, 2);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 8, 1);
        wait_done(0);
      end
      begin
        int kb, rb;
        @(negedge clk);
        start_run(1, 5, 3, kb, rb);
        wait_done(1);
        repeat (3) @(negedge clk);
        chk("b_cnt_hold", int'(cnt_s[1]), 2);
        start_run(1, 0, 0, kb, rb);
        wait_done(1);
      end
    join

    // Start during the done cycle is dropped; the next cycle's is taken.
    drive(0, 1'b1, 6, 3);
    @(negedge clk);
    start_run(0, 8, 1, k, r);

    // Reset in the middle of the third burst (cycles k+17..k+22).
    repeat (19) @(posedge clk);
    #3;
    rst_n = 1'b0;
    for (int i = exp_q.size() - 1; i >= 0; i--) if (exp_q[i].id == 0) exp_q.delete(i);
    #1;
    chk_idle(0, "async_reset_a");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle(0, "after_reset_a");
    start_run(0, 3, 2, k, r);
    wait_done(0);
    @(negedge clk);

    repeat (15) begin
      fork
        run_rand(0);
        run_rand(1);
      join
    end

    repeat (3) @(negedge clk);
    chk("leftover_events", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
